// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding and lamp patterns for the intersection controller
package traffic_pkg;

  // phase output carries the raw state value, so the order here is visible off-chip
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_NS = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_EW = 3'd5,
    WALK      = 3'd6
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_tick_detect.sv
// rtl/sec_tick_detect.sv - turns the 1 Hz level from the clock divider into one-cycle ticks
module sec_tick_detect (
  input  logic clock_in,
  input  logic rst_n,
  input  logic sec_level,
  output logic tick
);

  logic sec_q;

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) sec_q <= 1'b0;
    else        sec_q <= sec_level;
  end

  // a level already high out of reset counts as an edge on the first cycle
  assign tick = sec_level & ~sec_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-way intersection controller with a pedestrian walk phase
module traffic_light_fsm #(
  parameter int GREEN_SEC     = 20,
  parameter int MIN_GREEN_SEC = 5,
  parameter int YELLOW_SEC    = 3,
  parameter int ALLRED_SEC    = 1,
  parameter int WALK_SEC      = 8
) (
  input  logic       clock_in,
  input  logic       rst_n,
  input  logic       sec_level,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);
  import traffic_pkg::*;

  localparam int MAX_DUR = max2(max2(max2(GREEN_SEC, MIN_GREEN_SEC), max2(YELLOW_SEC, ALLRED_SEC)), WALK_SEC);
  localparam int CNT_W   = $clog2(MAX_DUR + 1);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_SEC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_SEC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_SEC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_SEC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_SEC - 1);

  if (GREEN_SEC < 1 || MIN_GREEN_SEC < 1 || YELLOW_SEC < 1 || ALLRED_SEC < 1 ||
      WALK_SEC < 1 || MIN_GREEN_SEC > GREEN_SEC) begin : g_param_check
    $fatal(1, "traffic_light_fsm: illegal phase duration parameters");
  end

  state_t           state, next_state;
  logic [CNT_W-1:0] sec_cnt;
  logic             ped_pend, ret_ns, next_ret_ns;
  logic             tick, exit_now, illegal, enter_walk;
  logic [2:0]       ns_nxt, ew_nxt;
  logic             walk_nxt;

  sec_tick_detect u_tick (
    .clock_in  (clock_in),
    .rst_n     (rst_n),
    .sec_level (sec_level),
    .tick      (tick)
  );

  always_comb begin
    exit_now    = 1'b0;
    illegal     = 1'b0;
    next_state  = state;
    next_ret_ns = ret_ns;

    case (state)
      NS_GREEN, EW_GREEN:   exit_now = (sec_cnt == GREEN_LAST) || (ped_pend && (sec_cnt >= MIN_LAST));
      NS_YELLOW, EW_YELLOW: exit_now = (sec_cnt == YELLOW_LAST);
      ALLRED_NS, ALLRED_EW: exit_now = (sec_cnt == ALLRED_LAST);
      WALK:                 exit_now = (sec_cnt == WALK_LAST);
      default:              illegal  = 1'b1;
    endcase

    // an unencoded state recovers at once rather than waiting for a tick
    if (illegal) begin
      next_state = ALLRED_EW;
    end else if (tick && exit_now) begin
      case (state)
        NS_GREEN:  next_state = NS_YELLOW;
        NS_YELLOW: next_state = ALLRED_NS;
        ALLRED_NS: begin
          next_state = ped_pend ? WALK : EW_GREEN;
          if (ped_pend) next_ret_ns = 1'b0;
        end
        EW_GREEN:  next_state = EW_YELLOW;
        EW_YELLOW: next_state = ALLRED_EW;
        ALLRED_EW: begin
          next_state = ped_pend ? WALK : NS_GREEN;
          if (ped_pend) next_ret_ns = 1'b1;
        end
        WALK:      next_state = ret_ns ? NS_GREEN : EW_GREEN;
        default:   next_state = ALLRED_EW;
      endcase
    end
  end

  assign enter_walk = (next_state == WALK) && (state != WALK);

  always_comb begin
    ns_nxt   = LIGHT_RED;
    ew_nxt   = LIGHT_RED;
    walk_nxt = 1'b0;
    case (next_state)
      NS_GREEN:  ns_nxt   = LIGHT_GRN;
      NS_YELLOW: ns_nxt   = LIGHT_YEL;
      EW_GREEN:  ew_nxt   = LIGHT_GRN;
      EW_YELLOW: ew_nxt   = LIGHT_YEL;
      WALK:      walk_nxt = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ALLRED_EW;
      sec_cnt  <= '0;
      ped_pend <= 1'b0;
      ret_ns   <= 1'b0;
      ns_light <= LIGHT_RED;
      ew_light <= LIGHT_RED;
      walk     <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) sec_cnt <= '0;
      else if (tick)           sec_cnt <= sec_cnt + 1'b1;
      // a request arriving with the walk entry is kept for the next round
      ped_pend <= ped_req | (ped_pend & ~enter_walk);
      ret_ns   <= next_ret_ns;
      ns_light <= ns_nxt;
      ew_light <= ew_nxt;
      walk     <= walk_nxt;
    end
  end

  assign phase = state;

endmodule
